// File: rtl/phy_rx_pkg.sv
// rtl/phy_rx_pkg.sv - shared types, constants and helpers for the multi-lane serial receiver
package phy_rx_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

  // Bits needed to hold values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/phy_rx_multilane_if.sv
// rtl/phy_rx_multilane_if.sv - lane data/control bundle between line side and striping logic
interface phy_rx_multilane_if #(
  parameter int LANES  = 2,
  parameter int WORD_W = 8
);
  logic                      enable;
  logic [LANES-1:0]          in;
  logic [LANES*WORD_W-1:0]   data_out;
  logic [LANES-1:0]          valid_out;
  logic [LANES-1:0]          strobe_out;
  logic [LANES-1:0]          active_out;
  logic                      all_active;

  modport master (
    output enable, in,
    input  data_out, valid_out, strobe_out, active_out, all_active
  );

  modport slave (
    input  enable, in,
    output data_out, valid_out, strobe_out, active_out, all_active
  );
endinterface

// File: rtl/phy_rx_lane.sv
// rtl/phy_rx_lane.sv - one lane: deserialiser, comma alignment FSM and word output registers
// Misaligned-comma relock is built only when PHY_RX_RELOCK_EN is defined.
module phy_rx_lane
  import phy_rx_pkg::*;
#(
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] COMMA      = WORD_W'(DEFAULT_COMMA),
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 2
) (
  input  logic              clk_8f,
  input  logic              reset_L,
  input  logic              enable,
  input  logic              in_bit,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              strobe_out,
  output logic              active_out
);

  localparam int BC_W = clog2(WORD_W);
  localparam int CC_W = clog2(LOCK_CNT + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [CC_W-1:0] CC_LOCK = CC_W'(LOCK_CNT);

  if (WORD_W < 4 || LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_bad_cfg
    $error("phy_rx_lane: unsupported parameter set");
  end

  logic [WORD_W-1:0] sh_q, sh_d, data_q, data_d, cand;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [CC_W-1:0]   ccnt_q, ccnt_d;
  lane_state_e       st_q, st_d;
  logic              valid_q, valid_d, strobe_q, strobe_d;
  logic              boundary, is_comma;

`ifdef PHY_RX_RELOCK_EN
  localparam int MC_W = clog2(UNLOCK_CNT + 1);
  localparam logic [MC_W-1:0] MC_UNLOCK = MC_W'(UNLOCK_CNT);
  logic [MC_W-1:0] mcnt_q, mcnt_d;
`endif

  assign cand     = {sh_q[WORD_W-2:0], in_bit};
  assign boundary = (bc_q == BC_LAST);
  assign is_comma = (cand == COMMA);

  always_comb begin
    sh_d     = sh_q;
    bc_d     = bc_q;
    ccnt_d   = ccnt_q;
    st_d     = st_q;
    data_d   = data_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
`ifdef PHY_RX_RELOCK_EN
    mcnt_d   = mcnt_q;
`endif
    if (enable) begin
      sh_d = cand;
      bc_d = boundary ? '0 : bc_q + 1'b1;
      unique case (st_q)
        SEARCH: begin
          // With no comma pending the search slides bit by bit; a hit re-phases bc.
          if (ccnt_q == '0) begin
            if (is_comma) begin
              bc_d   = '0;
              ccnt_d = CC_W'(1);
            end
          end else if (boundary) begin
            ccnt_d = is_comma ? ccnt_q + 1'b1 : '0;
          end
          if (ccnt_d == CC_LOCK) st_d = LOCKED;
        end
        LOCKED: begin
          if (boundary) begin
            strobe_d = 1'b1;
            valid_d  = !is_comma;
            if (!is_comma) data_d = cand;
          end
`ifdef PHY_RX_RELOCK_EN
          if (boundary) begin
            if (is_comma) mcnt_d = '0;
          end else if (is_comma) begin
            mcnt_d = mcnt_q + 1'b1;
            if (mcnt_d == MC_UNLOCK) begin
              st_d    = SEARCH;
              ccnt_d  = '0;
              mcnt_d  = '0;
              valid_d = 1'b0;
            end
          end
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_8f or negedge reset_L) begin
    if (!reset_L) begin
      sh_q     <= '0;
      bc_q     <= '0;
      ccnt_q   <= '0;
      st_q     <= SEARCH;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
`ifdef PHY_RX_RELOCK_EN
      mcnt_q   <= '0;
`endif
    end else begin
      sh_q     <= sh_d;
      bc_q     <= bc_d;
      ccnt_q   <= ccnt_d;
      st_q     <= st_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
`ifdef PHY_RX_RELOCK_EN
      mcnt_q   <= mcnt_d;
`endif
    end
  end

  // A disabled cycle must never present a word, even one registered just before.
  assign data_out   = data_q;
  assign valid_out  = valid_q & enable;
  assign strobe_out = strobe_q & enable;
  assign active_out = (st_q == LOCKED);

endmodule

// File: rtl/phy_rx_multilane.sv
// rtl/phy_rx_multilane.sv - LANES independent comma-aligned receivers on clk_8f
// Optional feature macro: PHY_RX_RELOCK_EN (relock on repeated misaligned commas).
module phy_rx_multilane
  import phy_rx_pkg::*;
#(
  parameter int                LANES      = 2,
  parameter int                WORD_W     = 8,
  parameter logic [WORD_W-1:0] COMMA      = WORD_W'(DEFAULT_COMMA),
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 2
) (
  input  logic               clk_8f,
  input  logic               reset_L,
  phy_rx_multilane_if.slave  bus
);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_rx_lane #(
      .WORD_W     (WORD_W),
      .COMMA      (COMMA),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lane (
      .clk_8f     (clk_8f),
      .reset_L    (reset_L),
      .enable     (bus.enable),
      .in_bit     (bus.in[i]),
      .data_out   (bus.data_out[i*WORD_W +: WORD_W]),
      .valid_out  (bus.valid_out[i]),
      .strobe_out (bus.strobe_out[i]),
      .active_out (bus.active_out[i])
    );
  end

  assign bus.all_active = &bus.active_out;

endmodule

// File: doc/phy_rx_multilane.md
Name: phy_rx_multilane

Overview:
- Parametrised multi-lane serial receiver: each lane deserialises a 1-bit stream into WORD_W-bit words, all on clk_8f.
- Each lane finds comma alignment at any bit offset and locks after LOCK_CNT consecutive aligned commas.
- Once locked, each lane delivers non-comma words with a valid flag.
- Successor to the fixed 2-lane, 8-bit, divided-clock receiver; sits between the serial line interface and the byte-striping/unstriping logic.

Parameters:
- LANES, 2, number of independent serial lanes.
- WORD_W, 8, bits per word (>=4).
- COMMA, 8'hBC, idle/alignment character (WORD_W bits).
- LOCK_CNT, 4, consecutive aligned commas required to lock (>=1).
- UNLOCK_CNT, 2, consecutive misaligned commas forcing relock (only with PHY_RX_RELOCK_EN).

Ports:
- clk_8f  in  1  bit clock; all logic on its rising edge.
- reset_L  in  1  asynchronous active-low reset.
- enable  in  1  global enable; low freezes all lanes.
- in  in  LANES  serial bit per lane, MSB first; lane i uses in[i].
- data_out  out  LANES*WORD_W  lane i word at [i*WORD_W +: WORD_W].
- valid_out  out  LANES  lane word is valid data; held for one word period.
- strobe_out  out  LANES  1-cycle pulse when lane word register updates.
- active_out  out  LANES  lane is in LOCKED.
- all_active  out  1  AND of active_out.

Behaviour:
- Reset (async, reset_L=0): all outputs 0; shift registers 0; bit counters 0; comma counters 0; every lane in SEARCH. The same applies mid-word, with no partial word emitted.
- enable=0: shift registers, counters and FSM states hold. valid_out and strobe_out are forced 0. data_out and active_out hold.
- Per lane, the shift register takes sh <= {sh[WORD_W-2:0], in[i]} every enabled cycle. The candidate word is cand = {sh[WORD_W-2:0], in[i]}.
- Bit counter bc counts 0..WORD_W-1 and wraps. A word boundary is the cycle with bc==WORD_W-1.
- SEARCH state:
  - Compare cand to COMMA every cycle (sliding).
  - On a match: set bc so that this cycle is a boundary (next bc=0), and set ccnt=1.
  - On later boundaries: cand==COMMA increments ccnt; any other value returns ccnt to 0 and resumes sliding search.
  - When ccnt reaches LOCK_CNT, go to LOCKED in the same edge. active_out rises on that edge.
  - LOCK_CNT=1 locks on the first match.
- LOCKED state, on each boundary:
  - data_out lane <= cand; strobe_out=1 for one cycle.
  - valid_out <= (cand != COMMA). A comma word keeps data_out at the previous value and sets valid_out to 0.
- Latency: the word whose last bit is sampled at edge n appears on data_out at edge n; it is registered from cand.
- Lanes are fully independent. They may lock at different offsets and times. Skew between lanes is not compensated.

Optional Feature:
- Macro: PHY_RX_RELOCK_EN.
- Defined:
  - In LOCKED, cand==COMMA at a non-boundary cycle increments mcnt. An aligned boundary word resets mcnt.
  - When mcnt reaches UNLOCK_CNT, the lane goes to SEARCH. active_out and valid_out drop on the next edge, and ccnt is cleared.
- Undefined: LOCKED is left only by reset_L=0; UNLOCK_CNT is unused.

Decomposition:
- Package phy_rx_pkg holds:
  - lane state enum (SEARCH, LOCKED);
  - default COMMA constant;
  - counter width function clog2 for bc, ccnt and mcnt.
- Sub-module phy_rx_lane: one lane (shift register, bc, FSM, counters, output registers).
- Top generates LANES instances and forms all_active.

Test Plan:
- Reset: hold reset_L=0 for 8 cycles, then assert it again mid-word -> all outputs 0; the lane stays in SEARCH with no strobe.
- Aligned lock: lanes 0/1 send BC x4 then FF/EE/DD -> active_out rises on the last bit of the 4th BC. data_out shows FF,EE,DD with valid=1, one strobe each 8 cycles.
- Offset lock: lane 1 is preceded by 3 stray bits, then BC x4 then 55 -> lane 1 locks 3 cycles after lane 0; data_out lane1=55; all_active=1 only after both lanes lock.
- Failed lock: BC x3, A5, BC x4 -> no lock after A5; lock after the 4th BC of the second run.
- Idle while locked: FF, BC, AA -> valid goes 1,0,1; data_out=FF held during BC, then AA.
- Enable freeze plus relock (PHY_RX_RELOCK_EN): enable=0 for 5 cycles mid-word -> no strobe and word resumes intact; then two BCs shifted 2 bits -> active_out falls, and the lane relocks after 4 aligned BCs.
